// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg
//   Shared definitions for the shift-and-add multiply sequencer.
//   ALU opcode constants match the ones the ALU and instruction decoder use.
//   state_t is the sequencer FSM state encoding.
package mult_sequencer_pkg;

    localparam logic [2:0] ALUOP_FWD = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Multi-cycle unsigned multiply built on the external combinational ALU
//   (ADD / FORWARD), one shift-and-add step per cycle with early exit once
//   no multiplier bits remain.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   START, MCAND, MPLIER  request + operands, accepted only in IDLE
//   BUSY                  high in RUN and DONE; selects this block onto the ALU
//   DONE                  one-cycle pulse, PRODUCT/OVF valid
//   PRODUCT, OVF          low WIDTH bits of the product, overflow flag
//   ALU_OP1/OP2/SEL       ALU drive, decoded from the current registers
//   ALU_RESULT            ALU output, written back on the next rising edge
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAXSTEPS = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] MCAND,
    input  logic [WIDTH-1:0] MPLIER,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] PRODUCT,
    output logic             OVF,
    output logic [WIDTH-1:0] ALU_OP1,
    output logic [WIDTH-1:0] ALU_OP2,
    output logic [2:0]       ALU_SEL,
    input  logic [WIDTH-1:0] ALU_RESULT
);

    localparam int CW = $clog2(MAXSTEPS);

    state_t           state;
    logic [WIDTH-1:0] a, b, acc;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic [WIDTH-1:0] b_next;
    logic             step_ovf;
    logic             last_step;

    assign b_next = b >> 1;

    // Overflow: the add wrapped, or a set multiplicand bit is about to be
    // shifted out while higher multiplier bits still have to be added.
    assign step_ovf  = (b[0] && (ALU_RESULT < acc)) ||
                       (a[WIDTH-1] && (b_next != '0));
    assign last_step = (b_next == '0) || (cnt == CW'(MAXSTEPS - 1));

    // ALU drive is a pure decode of registered state so the result settles
    // within the cycle and is captured on the next edge.
    always_comb begin
        ALU_OP1 = '0;
        ALU_OP2 = '0;
        ALU_SEL = ALUOP_FWD;
        if (state == S_RUN) begin
            if (b[0]) begin
                ALU_SEL = ALUOP_ADD;
                ALU_OP1 = acc;
                ALU_OP2 = a;
            end else begin
                ALU_SEL = ALUOP_FWD;
                ALU_OP2 = acc;
            end
        end
    end

    assign OVF = ovf;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PRODUCT <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a    <= MCAND;
                        b    <= MPLIER;
                        acc  <= '0;
                        cnt  <= '0;
                        ovf  <= 1'b0;
                        BUSY <= 1'b1;
                        if (MPLIER != '0) begin
                            state <= S_RUN;
                        end else begin
                            // Zero multiplier: skip RUN entirely.
                            state   <= S_DONE;
                            DONE    <= 1'b1;
                            PRODUCT <= '0;
                        end
                    end
                end
                S_RUN: begin
                    acc <= ALU_RESULT;
                    a   <= a << 1;
                    b   <= b_next;
                    cnt <= cnt + 1'b1;
                    if (step_ovf)
                        ovf <= 1'b1;
                    if (last_step) begin
                        state   <= S_DONE;
                        DONE    <= 1'b1;
                        PRODUCT <= ALU_RESULT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
//   Directed and random multiplies against an arithmetic reference
//   (product = mcand*mplier, latency from the multiplier's bit length),
//   with a behavioural ALU wired to the sequencer's ALU ports.
module tb_mult_sequencer;

    logic       CLK = 1'b0;
    logic       RESET, START;
    logic [7:0] MCAND, MPLIER;
    logic       BUSY, DONE, OVF;
    logic [7:0] PRODUCT, ALU_OP1, ALU_OP2, ALU_RESULT;
    logic [2:0] ALU_SEL;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    // Behavioural ALU sitting beside the sequencer.
    always_comb begin
        ALU_RESULT = 8'h00;
        case (ALU_SEL)
            3'b000:  ALU_RESULT = ALU_OP2;
            3'b001:  ALU_RESULT = ALU_OP1 + ALU_OP2;
            3'b010:  ALU_RESULT = ALU_OP1 & ALU_OP2;
            3'b011:  ALU_RESULT = ALU_OP1 | ALU_OP2;
            default: ALU_RESULT = 8'h00;
        endcase
    end

    mult_sequencer #(.WIDTH(8), .MAXSTEPS(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MCAND(MCAND), .MPLIER(MPLIER),
        .BUSY(BUSY), .DONE(DONE), .PRODUCT(PRODUCT), .OVF(OVF),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_SEL(ALU_SEL),
        .ALU_RESULT(ALU_RESULT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the sequencer idle. 'again' > 0 re-pulses START
    // so that it is sampled on posedge number 'again' after the accept edge.
    task automatic run(input logic [7:0] mc, input logic [7:0] mp, input int again);
        int  prod, exp_lat, j;
        bit  seen;
        prod    = int'(mc) * int'(mp);
        exp_lat = $clog2(int'(mp) + 1) + 1;   // RUN cycles + 1
        seen    = 1'b0;
        MCAND = mc; MPLIER = mp; START = 1'b1;
        @(posedge CLK); #1;
        chk("busy_rise", BUSY, 1);
        @(negedge CLK);
        START = 1'b0;
        MCAND = 8'($urandom); MPLIER = 8'($urandom);
        if (mp != 0) begin
            chk("alu_sel_step0", ALU_SEL, {2'b00, mp[0]});
            chk("alu_op2_step0", ALU_OP2, mp[0] ? mc : 8'h00);
        end
        for (j = 0; j <= 20; j++) begin
            if (j > 0) @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            START = (j + 1 == again);
            if (j + 1 == again) begin
                MCAND = 8'hFF; MPLIER = 8'h01;
            end
        end
        START = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", j + 1, exp_lat);
        chk("product", PRODUCT, prod & 255);
        chk("ovf", OVF, prod > 255);
        chk("busy_at_done", BUSY, 1);
        @(negedge CLK);
        chk("done_pulse_end", DONE, 0);
        chk("busy_fall", BUSY, 0);
        chk("product_hold", PRODUCT, prod & 255);
        chk("alu_sel_idle", ALU_SEL, 0);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; MCAND = 8'h00; MPLIER = 8'h00;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_product", PRODUCT, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_op1", ALU_OP1, 0);
        chk("rst_op2", ALU_OP2, 0);
        chk("rst_sel", ALU_SEL, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        run(8'd5,   8'd4,   0);
        run(8'd9,   8'd0,   0);
        run(8'd15,  8'd17,  0);
        run(8'd16,  8'd16,  0);
        run(8'd3,   8'd3,   0);
        run(8'd200, 8'd128, 3);
        run(8'd3,   8'd3,   0);

        // Reset in the middle of a long multiply.
        MCAND = 8'd7; MPLIER = 8'd255; START = 1'b1;
        @(posedge CLK); #1;
        chk("mid_busy", BUSY, 1);
        @(negedge CLK); START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_product", PRODUCT, 0);
        chk("abort_ovf", OVF, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("abort_no_done", DONE, 0);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_abort_idle", {BUSY, DONE}, 0);
        end
        run(8'd2, 8'd3, 0);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] mc, mp;
            mc = 8'($urandom);
            mp = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            run(mc, mp, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
